// File: rtl/wrbuf_cntl_q.sv
// Write-back buffer controller: captures replaced dirty lines into ENTRIES slots
// and drains each one to memory as WORDS beats, with NC stores ordered behind them.
//
// state | meaning
// IDLE  | no memory request; waiting for a drainable line or an NC store
// REQ   | write-back beat request outstanding (beat counter selects the word)
// NC_WR | single-beat non-cacheable store request outstanding
// ERR   | one-cycle error report after an errored beat
module wrbuf_cntl_q #(
    parameter int WORDS   = 4,
    parameter int CAPC    = 2,
    parameter int ENTRIES = 2,
    parameter int PW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             repl_start,
    input  logic             drain_go,
    input  logic             nc_write_c,
    input  logic             normal_ack,
    input  logic             error_ack,
    input  logic             miss_idle,
    output logic [CAPC-1:0]  wb_ce,
    output logic [PW-1:0]    wb_wr_ptr,
    output logic [PW-1:0]    wb_rd_ptr,
    output logic [WORDS-1:0] wb_sel,
    output logic             repl_busy,
    output logic             wb_req,
    output logic             real_wb_req,
    output logic             nc_write_cyc,
    output logic             nc_stall,
    output logic             wb_idle,
    output logic             wb_full,
    output logic             wb_empty,
    output logic             wb_err,
    output logic             wb_ovf
);

    localparam int CW = (CAPC > 1) ? $clog2(CAPC) : 1;
    localparam int BW = $clog2(WORDS);
    localparam logic [CW-1:0] CAP_LAST  = CW'(CAPC - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(WORDS - 1);
    localparam logic [PW-1:0] SLOT_LAST = PW'(ENTRIES - 1);
    localparam logic [PW:0]   CNT_FULL  = (PW + 1)'(ENTRIES);
    localparam logic [PW:0]   CNT_ONE   = (PW + 1)'(1);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        REQ   = 4'b0010,
        NC_WR = 4'b0100,
        ERR   = 4'b1000
    } state_t;

    state_t        state;
    logic [BW-1:0] beat;
    logic          cap_active;
    logic [CW-1:0] cap_cnt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          go;
    logic          ovf;

    logic full;
    logic cap_done;
    logic drain_en;
    logic beat_adv;
    logic pop;
    logic nc_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == SLOT_LAST) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CNT_FULL);
    assign cap_done = cap_active && (cap_cnt == CAP_LAST);
    assign drain_en = (count != '0) && (go || drain_go || full);
    // Beat 0 waits for the miss machine so a write-back never races a line fill.
    assign beat_adv = normal_ack && ((beat != '0) || miss_idle);
    assign pop      = (state == REQ) && (error_ack || (beat_adv && (beat == BEAT_LAST)));
    assign nc_ok    = (state == IDLE) && (count == '0) && !cap_active && !drain_en;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            cap_active <= 1'b0;
            cap_cnt    <= '0;
            wr_ptr     <= '0;
            ovf        <= 1'b0;
        end else begin
            if (cap_active) begin
                cap_cnt <= cap_cnt + 1'b1;
                if (cap_done) begin
                    cap_active <= 1'b0;
                end
            end else if (repl_start && !full) begin
                cap_active <= 1'b1;
                cap_cnt    <= '0;
            end
            if (repl_start && full) begin
                ovf <= 1'b1;
            end
            if (cap_done) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            count <= '0;
            go    <= 1'b0;
        end else begin
            case ({cap_done, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new drain_go wins over the clear so a grant for the next line is not lost.
            go <= drain_go || (go && !(pop && !cap_done && (count == CNT_ONE)));
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state  <= IDLE;
            beat   <= '0;
            rd_ptr <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case (state)
                IDLE: begin
                    if (drain_en) begin
                        state <= REQ;
                        beat  <= '0;
                    end else if (nc_write_c && (count == '0) && !cap_active) begin
                        state <= NC_WR;
                    end
                end
                REQ: begin
                    if (error_ack) begin
                        state <= ERR;
                    end else if (beat_adv) begin
                        if (beat == BEAT_LAST) begin
                            state <= IDLE;
                        end
                        beat <= beat + 1'b1;
                    end
                end
                NC_WR: begin
                    if (error_ack) begin
                        state <= ERR;
                    end else if (normal_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wb_ce        = cap_active ? (CAPC'(1) << cap_cnt) : '0;
    assign wb_wr_ptr    = wr_ptr;
    assign wb_rd_ptr    = rd_ptr;
    assign wb_sel       = (state == REQ) ? (WORDS'(1) << beat) : WORDS'(1);
    assign repl_busy    = cap_active;
    assign real_wb_req  = (state == REQ);
    assign nc_write_cyc = (state == NC_WR);
    assign wb_req       = (state == REQ) || (state == NC_WR);
    assign wb_err       = (state == ERR);
    assign wb_idle      = (state == IDLE);
    assign wb_full      = full;
    assign wb_empty     = (count == '0) && !cap_active;
    assign wb_ovf       = ovf;
    assign nc_stall     = nc_write_c && !nc_ok;

endmodule

// File: doc/wrbuf_cntl_q.md
# wrbuf_cntl_q

Parametrised multi-entry write-back buffer controller for the DCU. It sequences the capture of replaced dirty lines into a FIFO of ENTRIES line slots, each filled over CAPC capture cycles, and drains each complete line to memory as WORDS acknowledged beats. It also arbitrates non-cacheable (NC) single-beat stores against pending write-backs. It sits between the DCU miss/replacement logic and the memory interface; the write-buffer data RAM is external and is driven by the enable, select and pointer outputs.

## Interface
- WORDS, 4: beats per line drained to memory; power of 2, range 2..16.
- CAPC, 2: capture cycles per line (one bank pair per cycle); power of 2, range 1..WORDS.
- ENTRIES, 2: line slots in buffer; power of 2, range 1..8.
- PW, log2(ENTRIES) (minimum 1): pointer width.

Ports:
- clk  in  1  clock.
- reset_l  in  1  asynchronous active-low reset.
- repl_start  in  1  dirty line available; capture starts next cycle.
- drain_go  in  1  pulse: permission to drain (first fill cycle, flush C2, NA-store fill, dc_error), OR'd by the source.
- nc_write_c  in  1  NC store in C stage.
- normal_ack  in  1  current memory beat completed.
- error_ack  in  1  current memory beat errored.
- miss_idle  in  1  miss state machine idle.
- wb_ce  out  CAPC  one-hot capture enable, bit k in capture cycle k.
- wb_wr_ptr  out  PW  slot being captured.
- wb_rd_ptr  out  PW  slot being drained.
- wb_sel  out  WORDS  one-hot beat select; bit 0 when not draining.
- repl_busy  out  1  capture in progress.
- wb_req  out  1  memory request (write-back or NC).
- real_wb_req  out  1  write-back request only.
- nc_write_cyc  out  1  NC write in progress.
- nc_stall  out  1  NC store in C cannot be accepted this cycle.
- wb_idle  out  1  drain FSM in IDLE.
- wb_full  out  1  count == ENTRIES.
- wb_empty  out  1  count == 0 and not capturing.
- wb_err  out  1  one-cycle pulse in ERR state.
- wb_ovf  out  1  sticky: repl_start seen while wb_full; cleared only by reset.

## Operation
- Capture: repl_start at cycle t (accepted when neither capturing nor wb_full) starts capture cycles t+1..t+CAPC.
  - wb_ce[k] is high at t+1+k; repl_busy is high over the same cycles.
  - At the end of cycle t+CAPC: wb_wr_ptr increments mod ENTRIES and count increments.
  - repl_start while capturing is ignored. repl_start while wb_full is ignored and sets wb_ovf.
- Drain enable: a go flag is set by drain_go and cleared when count reaches 0. Drain is enabled when count>0 and (go or wb_full).
- Drain FSM states: IDLE, REQ, NC_WR, ERR (one-hot; reset to IDLE).
  - IDLE -> REQ when drain enabled; beat counter = 0.
  - Else IDLE -> NC_WR when nc_write_c, count==0 and !repl_busy.
  - Else stay in IDLE.
  - REQ: error_ack -> ERR, slot popped (rd_ptr+1, count-1), data discarded.
  - REQ, beat 0: advances on normal_ack & miss_idle. Beats >0: advance on normal_ack.
  - REQ, last beat (WORDS-1) normal_ack: pop slot -> IDLE.
  - NC_WR: error_ack -> ERR (no pop); normal_ack -> IDLE.
  - ERR -> IDLE unconditionally.
  - error_ack has priority over normal_ack when both are high.
- Outputs:
  - wb_sel = one-hot(beat) in REQ, else bit 0.
  - real_wb_req = REQ; nc_write_cyc = NC_WR; wb_req = REQ | NC_WR; wb_err = ERR.
  - nc_stall = nc_write_c & !(IDLE & count==0 & !repl_busy & !drain enabled). NC stores are thereby ordered behind all buffered lines.
- Capture completion and pop in the same cycle leave count unchanged; both pointers advance.
- Pointers wrap mod ENTRIES. count is PW+1 bits.

## Timing
- Reset (asynchronous, any cycle, including mid-capture or mid-drain):
  - FSM = IDLE, pointers = 0, count = 0, go = 0, wb_ovf = 0.
  - Outputs: wb_idle=1, wb_empty=1, wb_sel=1 (bit 0 set), all other outputs 0.
- All outputs are decoded from registered state only; no input-to-output combinational path except nc_stall.
- repl_start to first wb_ce: 1 cycle. Line valid for drain: CAPC+1 cycles after repl_start.
- Earliest wb_req: the cycle after a slot becomes valid while drain is enabled.
- At least one IDLE cycle separates consecutive lines and NC writes.
- Minimum line drain time: WORDS cycles of wb_req, plus 1 IDLE cycle.

## Test plan
- Defaults: repl_start@0 -> wb_ce=01@1, 10@2, count=1@3. drain_go@3 -> wb_req@4. Ack every cycle with miss_idle=1 -> wb_sel 0001,0010,0100,1000 @4..7; wb_empty=1@8.
- miss_idle=0 during beat 0 with normal_ack high for 3 cycles -> beat stays 0, wb_sel=0001, until miss_idle=1.
- Two captures without drain_go -> wb_full=1. Drain starts the next cycle with no drain_go. A third repl_start -> ignored, wb_ovf=1.
- nc_write_c with count=1 -> nc_stall=1 until the line drains. Then NC_WR: nc_write_cyc=1, real_wb_req=0. normal_ack -> IDLE.
- error_ack on beat 2 -> ERR for 1 cycle with wb_err=1, count decrements, wb_rd_ptr increments. error_ack and normal_ack together -> ERR.
- Reset asserted mid-beat 1 -> all outputs at reset values immediately; wb_ovf cleared. ENTRIES=1, WORDS=8, CAPC=4 build -> 8 beats, 4 wb_ce cycles, pointers stay 0.
